// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage of the RV64I pipeline, feeding the IF/ID register.
//   Owns the fetch PC, issues one word request at a time to instruction memory
//   (req/ready handshake, response flagged by rsp_valid), and buffers returned
//   words with their PCs in a 2-entry queue whose head is presented downstream.
//   A jump/branch redirect (jb) flushes the queue, squashes any in-flight
//   response and restarts fetching at the aligned jb_target.
//
// Configuration macro: IF_PERF_EN adds perf_fetch_cnt / perf_bubble_cnt.
//
// Ports
//   clk             in   1   clock, rising edge
//   rst             in   1   reset, asynchronous, active-low
//   stall           in   1   downstream hold; queue head is not consumed
//   jb              in   1   redirect; flush queue, restart at jb_target
//   jb_target       in   64  redirect PC; bits [1:0] ignored
//   imem_req        out  1   request valid
//   imem_addr       out  64  request word address
//   imem_ready      in   1   memory accepts request this cycle
//   imem_rsp_valid  in   1   response data valid
//   imem_rsp_data   in   32  response instruction word
//   current_pc      out  64  PC of presented instruction
//   inst            out  32  presented instruction (NOP when empty)
//   inst_valid      out  1   queue head is valid
//   perf_fetch_cnt  out  32  (IF_PERF_EN) instructions handed downstream
//   perf_bubble_cnt out  32  (IF_PERF_EN) cycles downstream ready but starved
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        jb,
  input  logic [63:0] jb_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [63:0] current_pc,
  output logic [31:0] inst,
  output logic        inst_valid
`ifdef IF_PERF_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic [63:0] r_fetch_pc;
  logic [63:0] r_req_pc;
  logic        r_squash;
  logic        r_head;
  logic [1:0]  r_count;
  logic [63:0] r_q_pc   [QDEPTH];
  logic [31:0] r_q_inst [QDEPTH];

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic w_rsp;
  logic w_push;
  logic w_pop;
  logic w_accept;
  logic w_tail;
  logic w_unused_tgt_lsbs;

  // Only responses that arrive while a request is outstanding count.
  assign w_rsp    = (r_state == S_WAIT) && imem_rsp_valid;
  assign w_push   = w_rsp && !r_squash && !jb;
  assign w_pop    = inst_valid && !stall && !jb;

  // Gating with rst keeps the request low for the whole time reset is held,
  // even though the FSM already sits in IDLE with an empty queue.
  assign imem_req = rst && (r_state == S_IDLE) && !jb && (32'(r_count) < QDEPTH);
  assign w_accept = imem_req && imem_ready;
  assign imem_addr = r_fetch_pc;

  // A push only happens with at most one entry held, so the slot after the
  // head (or the head itself when empty) is always the free one.
  assign w_tail = r_head ^ r_count[0];

  assign inst_valid = (r_count != 2'd0);
  assign current_pc = inst_valid ? r_q_pc[r_head]   : r_fetch_pc;
  assign inst       = inst_valid ? r_q_inst[r_head] : NOP;

  assign w_unused_tgt_lsbs = ^jb_target[1:0];

  // ---------------------------------------------------------------------------
  // FSM, PCs and queue occupancy
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_squash   <= 1'b0;
      r_head     <= 1'b0;
      r_count    <= 2'd0;
    end else if (jb) begin
      r_count    <= 2'd0;
      r_fetch_pc <= {jb_target[63:2], 2'b00};
      if (r_state == S_WAIT) begin
        if (imem_rsp_valid) begin
          // Response lands with the redirect: drop it, nothing left in flight.
          r_state  <= S_IDLE;
          r_squash <= 1'b0;
        end else begin
          // The in-flight response belongs to the old path; discard it later.
          r_squash <= 1'b1;
        end
      end
    end else begin
      if (w_accept) begin
        r_req_pc   <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + 64'd4;
        r_state    <= S_WAIT;
      end
      if (w_rsp) begin
        r_state  <= S_IDLE;
        r_squash <= 1'b0;
      end
      if (w_pop) begin
        r_head <= ~r_head;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Queue storage
  // ---------------------------------------------------------------------------
  // NOTE: the entry storage has no reset; occupancy is tracked by r_count and
  // empty-queue outputs are muxed to fixed values, so stale data never leaks.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_pc[w_tail]   <= r_req_pc;
      r_q_inst[w_tail] <= imem_rsp_data;
    end
  end

`ifdef IF_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters (free-running, wrap at 2^32)
  // ---------------------------------------------------------------------------
  logic [31:0] r_perf_fetch_cnt;
  logic [31:0] r_perf_bubble_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_fetch_cnt  <= 32'd0;
      r_perf_bubble_cnt <= 32'd0;
    end else begin
      if (w_pop) begin
        r_perf_fetch_cnt <= r_perf_fetch_cnt + 32'd1;
      end
      // Downstream would have taken an instruction but none was ready.
      if (!stall && !jb && !inst_valid) begin
        r_perf_bubble_cnt <= r_perf_bubble_cnt + 32'd1;
      end
    end
  end

  assign perf_fetch_cnt  = r_perf_fetch_cnt;
  assign perf_bubble_cnt = r_perf_bubble_cnt;
`endif

endmodule
